// File: rtl/led_panel_pkg.sv
// Shared constants and FSM state type for the LED panel write scheduler.
package led_panel_pkg;
  localparam int         LED_W         = 21;
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;
endpackage

// File: rtl/led_panel_write_scheduler_if.sv
// Avalon-MM write-only bus between the scheduler and the LED PIO data register.
interface led_panel_write_scheduler_if;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_waitrequest
  );
endinterface

// File: rtl/led_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first valid
// requester at or above ptr, wrapping around.
module led_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = (PTR_W+1)'(ptr) + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      cand = sum[PTR_W-1:0];
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/led_panel_write_scheduler.sv
// Shares the LED panel PIO between NUM_REQ requesters via masked updates to a shadow image.
// Optional blink/refresh logic is built when LED_BLINK_EN is defined.
module led_panel_write_scheduler
  import led_panel_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int LED_W     = led_panel_pkg::LED_W,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*LED_W-1:0] req_mask,
  input  logic [NUM_REQ*LED_W-1:0] req_value,
  output logic [NUM_REQ-1:0]       req_ready,
`ifdef LED_BLINK_EN
  input  logic [LED_W-1:0]         blink_mask,
`endif
  led_panel_write_scheduler_if.master bus,
  output logic [LED_W-1:0]         led_state
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || LED_W < 1 || LED_W > 32 || BLINK_DIV < 1) begin : g_bad_param
    $error("led_panel_write_scheduler: parameter out of range");
  end

  state_t             state, state_next;
  logic [LED_W-1:0]   shadow, image_merged, image_out, mask_g, value_g;
  logic [PTR_W-1:0]   ptr, grant_idx, ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any, launch;
  logic [31:0]        writedata_q;

  led_rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .valid     (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    mask_g  = '0;
    value_g = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mask_g  = req_mask[i*LED_W +: LED_W];
        value_g = req_value[i*LED_W +: LED_W];
      end
    end
  end

  assign image_merged = grant_any ? ((shadow & ~mask_g) | (value_g & mask_g)) : shadow;
  assign ptr_next     = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

`ifdef LED_BLINK_EN
  localparam int PS_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PS_W-1:0] prescaler;
  logic            phase, refresh_pending, wrap;

  assign wrap      = (prescaler == PS_W'(BLINK_DIV - 1));
  assign launch    = (state == IDLE) && (grant_any || refresh_pending);
  assign image_out = image_merged & ~(blink_mask & {LED_W{phase}});

  // A wrap on the same edge as a launch must leave a refresh pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler       <= '0;
      phase           <= 1'b0;
      refresh_pending <= 1'b0;
    end else begin
      prescaler <= wrap ? '0 : prescaler + 1'b1;
      if (wrap) phase <= ~phase;
      if (wrap) refresh_pending <= 1'b1;
      else if (launch) refresh_pending <= 1'b0;
    end
  end
`else
  assign launch    = (state == IDLE) && grant_any;
  assign image_out = image_merged;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow      <= '0;
      ptr         <= '0;
      writedata_q <= '0;
    end else if (launch) begin
      shadow      <= image_merged;
      writedata_q <= 32'(image_out);
      if (grant_any) ptr <= ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = WRITE;
      WRITE:   if (!bus.avm_waitrequest) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready          = '0;
    bus.avm_chipselect = 1'b0;
    bus.avm_write_n    = 1'b1;
    case (state)
      IDLE:  req_ready = grant;
      WRITE: begin
        bus.avm_chipselect = 1'b1;
        bus.avm_write_n    = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.avm_address   = PIO_DATA_ADDR;
  assign bus.avm_writedata = writedata_q;
  assign led_state         = shadow;

endmodule

// File: tb/tb_led_panel_write_scheduler.sv
// Directed plus randomized bench for led_panel_write_scheduler against a transaction-level model.
module tb_led_panel_write_scheduler;
  localparam int NUM_REQ = 4;
  localparam int LED_W   = 21;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid, req_ready;
  logic [NUM_REQ*LED_W-1:0] req_mask, req_value;
  logic [LED_W-1:0]         led_state;
`ifdef LED_BLINK_EN
  logic [LED_W-1:0]         blink_mask = '0;
`endif

  led_panel_write_scheduler_if bus();

  always #5 clk = ~clk;

  led_panel_write_scheduler #(.NUM_REQ(NUM_REQ), .LED_W(LED_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_mask  (req_mask),
    .req_value (req_value),
    .req_ready (req_ready),
`ifdef LED_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .bus       (bus),
    .led_state (led_state)
  );

  // Requester intent and reference model state.
  bit               v   [NUM_REQ];
  logic [LED_W-1:0] msk [NUM_REQ];
  logic [LED_W-1:0] val [NUM_REQ];
  logic [LED_W-1:0] m_shadow = '0;
  logic [31:0]      m_wdata  = '0;
  logic             m_busy   = 1'b0;
  int               m_ptr    = 0;

  int          n_assert = 0, n_fail = 0, cyc = 0;
  logic [31:0] dut_wr_q[$];
  logic [31:0] dut_g_q[$];
  int          dut_gcyc[$];
  int          mark;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]                 = v[i];
      req_mask[i*LED_W +: LED_W]  = msk[i];
      req_value[i*LED_W +: LED_W] = val[i];
    end
  endtask

  // One clock: compare DUT with model, then advance model across the edge.
  task automatic cycle();
    int g;
    logic [NUM_REQ-1:0] exp_ready;
    drive();
    #1;
    g = -1;
    exp_ready = '0;
    if (!m_busy) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int c;
        c = (m_ptr + k) % NUM_REQ;
        if (g < 0 && v[c]) g = c;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("chipselect", 32'(bus.avm_chipselect), 32'(m_busy));
    chk("write_n", 32'(bus.avm_write_n), 32'(!m_busy));
    chk("address", 32'(bus.avm_address), 32'd0);
    chk("led_state", 32'(led_state), 32'(m_shadow));
    if (m_busy) begin
      chk("writedata", bus.avm_writedata, m_wdata);
      chk("writedata_hi", 32'(bus.avm_writedata[31:LED_W]), 32'd0);
    end
    if (req_ready != '0) begin
      dut_g_q.push_back(32'(req_ready));
      dut_gcyc.push_back(cyc);
    end
    if (bus.avm_chipselect && !bus.avm_write_n && !bus.avm_waitrequest)
      dut_wr_q.push_back(bus.avm_writedata);
    if (reset) begin
      m_shadow = '0; m_wdata = '0; m_busy = 1'b0; m_ptr = 0;
    end else if (g >= 0) begin
      m_shadow = (m_shadow & ~msk[g]) | (val[g] & msk[g]);
      m_wdata  = 32'(m_shadow);
      m_ptr    = (g + 1) % NUM_REQ;
      m_busy   = 1'b1;
      v[g]     = 1'b0;
    end else if (m_busy && !bus.avm_waitrequest) begin
      m_busy = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    dut_wr_q.delete();
    dut_g_q.delete();
    dut_gcyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic req(input int i, input logic [LED_W-1:0] m, input logic [LED_W-1:0] d);
    v[i] = 1'b1; msk[i] = m; val[i] = d;
  endtask

  initial begin
    reset = 1'b1;
    bus.avm_waitrequest = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = 1'b0; msk[i] = '0; val[i] = '0;
    end
    drive();
    @(negedge clk);
    do_reset();

    // Single masked update from requester 0.
    clear_logs();
    req(0, 21'h00000F, 21'h000005);
    repeat (4) cycle();
    chk("t1_nwrites", 32'(dut_wr_q.size()), 32'd1);
    chk("t1_wdata", dut_wr_q[0], 32'h5);
    chk("t1_nready", 32'(dut_g_q.size()), 32'd1);
    chk("t1_led", 32'(led_state), 32'h5);

    // Four simultaneous requesters from a fresh reset.
    do_reset();
    clear_logs();
    for (int i = 0; i < NUM_REQ; i++) req(i, LED_W'(1 << i), LED_W'(1 << i));
    repeat (10) cycle();
    chk("t2_ngrants", 32'(dut_g_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_grant", dut_g_q[i], 32'(1 << i));
      chk("t2_wdata", dut_wr_q[i], 32'((1 << (i + 1)) - 1));
    end
    for (int i = 0; i < 3; i++) chk("t2_spacing", 32'(dut_gcyc[i+1] - dut_gcyc[i]), 32'd2);
    chk("t2_led", 32'(led_state), 32'h00000F);

    // Stall for 3 cycles with a zero-mask request waiting.
    clear_logs();
    req(2, 21'h000010, 21'h000010);
    req(3, 21'h000000, 21'h1FFFFF);
    cycle();
    bus.avm_waitrequest = 1'b1;
    repeat (3) cycle();
    chk("t3_no_write_in_stall", 32'(dut_wr_q.size()), 32'd0);
    bus.avm_waitrequest = 1'b0;
    cycle();
    chk("t3_one_write", 32'(dut_wr_q.size()), 32'd1);
    chk("t3_ready_in_stall", 32'(dut_g_q.size()), 32'd1);
    repeat (4) cycle();
    chk("t3_mask0_write", 32'(dut_wr_q.size()), 32'd2);
    chk("t3_mask0_data", dut_wr_q[1], 32'h00001F);

    // Bit 20 set then cleared by another requester.
    do_reset();
    clear_logs();
    req(1, 21'h100000, 21'h100000);
    repeat (3) cycle();
    req(2, 21'h100000, 21'h000000);
    repeat (3) cycle();
    chk("t4_nwrites", 32'(dut_wr_q.size()), 32'd2);
    chk("t4_first", dut_wr_q[0], 32'h100000);
    chk("t4_second", dut_wr_q[1], 32'h000000);

    // Reset in the cycle following an accept.
    req(2, 21'h0000FF, 21'h0000AA);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    chk("t5_cs", 32'(bus.avm_chipselect), 32'd0);
    chk("t5_wn", 32'(bus.avm_write_n), 32'd1);
    chk("t5_led", 32'(led_state), 32'd0);
    clear_logs();
    req(1, 21'h000003, 21'h000001);
    req(3, 21'h00000C, 21'h000008);
    cycle();
    chk("t5_ptr0_grant", dut_g_q[0], 32'b0010);
    repeat (4) cycle();

    // Randomized traffic with stalls, overlapping masks and occasional resets.
    mark = n_fail;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          msk[i] = ($urandom_range(0, 7) == 0) ? '0 : LED_W'($urandom);
          val[i] = LED_W'($urandom);
          v[i]   = 1'b1;
        end
      end
      bus.avm_waitrequest = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;
    bus.avm_waitrequest = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) v[i] = 1'b0;
    repeat (3) cycle();
    chk("rand_drain_idle", 32'(bus.avm_chipselect), 32'd0);
    if (n_fail != mark) $display("random phase saw %0d new errors", n_fail - mark);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
